// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the Ibex instruction/data SRAM arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_BE_W   = 4;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // True when addr falls inside the power-of-two window [start, start+size).
    function automatic logic in_window(
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [MEM_ADDR_W-1:0] start,
        input logic [MEM_ADDR_W-1:0] size
    );
        return ((addr & ~(size - MEM_ADDR_W'(1))) == start);
    endfunction

endpackage

// File: rtl/mem_arb_resp_reg.sv
// One-cycle response stage: remembers who was granted last cycle and steers
// the SRAM read data (or a bus error) back to that owner only.
module mem_arb_resp_reg
    import mem_arb_pkg::*;
(
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        i_load,
    input  logic        i_owner_data,
    input  logic        i_err,
    input  logic        i_we,
    input  logic [31:0] i_mem_rdata,
    output logic        o_instr_rvalid,
    output logic [31:0] o_instr_rdata,
    output logic        o_instr_err,
    output logic        o_data_rvalid,
    output logic [31:0] o_data_rdata,
    output logic        o_data_err
);

    logic   r_valid;
    owner_e r_owner;
    logic   r_err;
    logic   r_rd;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_valid <= 1'b0;
            r_owner <= OWNER_INSTR;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_valid <= i_load;
            r_owner <= i_owner_data ? OWNER_DATA : OWNER_INSTR;
            r_err   <= i_load & i_err;
            r_rd    <= i_load & ~i_err & ~i_we;
        end
    end

    logic        w_instr_own;
    logic        w_data_own;
    logic [31:0] w_rdata;

    always_comb begin
        w_instr_own = r_valid & (r_owner == OWNER_INSTR);
        w_data_own  = r_valid & (r_owner == OWNER_DATA);
        // Writes and errors return zero data rather than stale SRAM output.
        w_rdata     = r_rd ? i_mem_rdata : 32'h0;
    end

    assign o_instr_rvalid = w_instr_own;
    assign o_instr_rdata  = w_instr_own ? w_rdata : 32'h0;
    assign o_instr_err    = w_instr_own & r_err;
    assign o_data_rvalid  = w_data_own;
    assign o_data_rdata   = w_data_own ? w_rdata : 32'h0;
    assign o_data_err     = w_data_own & r_err;

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Fetch/LSU arbiter in front of a single-port SRAM with bounded data starvation.
// Define MEM_ARB_STATS_EN to build the stall_cnt_o contention counter.
module ibex_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] MEM_START = 32'h0000_0000,
    parameter int          MEM_SIZE  = 8192,
    parameter int          MAX_WAIT  = 4
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] stall_cnt_o
);

    localparam logic [7:0]  LP_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [31:0] LP_SIZE     = 32'(MEM_SIZE);

    logic [7:0]  r_starve;
    logic [7:0]  w_starve_next;
    logic        w_sel_data;
    logic        w_instr_gnt;
    logic        w_data_gnt;
    logic        w_any_gnt;
    logic [31:0] w_addr;
    logic        w_in_range;
    logic        w_mem_req;
    logic        w_we;

    // Grants are gated by reset so every output reads zero while it is held.
    always_comb begin
        w_sel_data  = data_req_i & (~instr_req_i | (r_starve == LP_MAX_WAIT));
        w_instr_gnt = rst_sys_n & instr_req_i & ~w_sel_data;
        w_data_gnt  = rst_sys_n & w_sel_data;
        w_any_gnt   = w_instr_gnt | w_data_gnt;
        w_addr      = w_sel_data ? data_addr_i : instr_addr_i;
        w_in_range  = in_window(w_addr, MEM_START, LP_SIZE);
        w_mem_req   = w_any_gnt & w_in_range;
        w_we        = w_sel_data & data_we_i;
    end

    always_comb begin
        mem_req_o   = w_mem_req;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (w_mem_req) begin
            mem_addr_o = w_addr;
            if (w_sel_data) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
            end
        end
    end

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    always_comb begin
        w_starve_next = r_starve;
        if (!data_req_i || w_data_gnt) begin
            w_starve_next = 8'h0;
        end else if (w_instr_gnt && (r_starve != LP_MAX_WAIT)) begin
            w_starve_next = r_starve + 8'h1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_starve <= 8'h0;
        end else begin
            r_starve <= w_starve_next;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (instr_req_i & ~w_instr_gnt) | (data_req_i & ~w_data_gnt);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_stall_cnt <= 32'h0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'h1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

    mem_arb_resp_reg u_resp_reg (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .i_load         (w_any_gnt),
        .i_owner_data   (w_data_gnt),
        .i_err          (~w_in_range),
        .i_we           (w_we),
        .i_mem_rdata    (mem_rdata_i),
        .o_instr_rvalid (instr_rvalid_o),
        .o_instr_rdata  (instr_rdata_o),
        .o_instr_err    (instr_err_o),
        .o_data_rvalid  (data_rvalid_o),
        .o_data_rdata   (data_rdata_o),
        .o_data_err     (data_err_o)
    );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter with a behavioural 1-cycle SRAM model.
module tb_ibex_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [31:0] stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    ibex_mem_arbiter #(
        .MEM_START (32'h0000_0000),
        .MEM_SIZE  (8192),
        .MAX_WAIT  (4)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .stall_cnt_o    (stall_cnt_o)
    );

    // SRAM model: one process owns the array; the bench preloads through tb_wr_*.
    logic [31:0] r_ram [0:2047] = '{default: 32'h0};
    logic [31:0] r_ram_rdata = 32'h0;
    logic        tb_wr_en = 1'b0;
    logic [10:0] tb_wr_idx = 11'h0;
    logic [31:0] tb_wr_val = 32'h0;

    assign mem_rdata_i = r_ram_rdata;

    always @(posedge clk_sys) begin
        if (tb_wr_en) begin
            r_ram[tb_wr_idx] <= tb_wr_val;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) r_ram[mem_addr_o[12:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                r_ram_rdata <= r_ram[mem_addr_o[12:2]];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive_idle();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic drive_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
    endtask

    logic [31:0] exp_stall;

    initial begin
        // Reset with both requests high: every output must still be zero.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        drive_data(1'b0, 4'hF, 32'h100, 32'h0);
        tb_wr_en  = 1'b1;
        tb_wr_idx = 11'h20;
        tb_wr_val = 32'h0000_0013;
        @(negedge clk_sys);
        check_val("rst_instr_gnt", {31'h0, instr_gnt_o}, 32'h0);
        check_val("rst_data_gnt", {31'h0, data_gnt_o}, 32'h0);
        check_val("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        check_val("rst_mem_addr", mem_addr_o, 32'h0);
        check_val("rst_rvalids", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        check_val("rst_stall", stall_cnt_o, 32'h0);
        @(negedge clk_sys);
        tb_wr_en = 1'b0;
        drive_idle();
        rst_sys_n = 1'b1;

        // Single fetch of 0x80.
        next_cycle();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        @(negedge clk_sys);
        check_val("f1_gnt", {31'h0, instr_gnt_o}, 32'h1);
        check_val("f1_mem_be", {28'h0, mem_be_o}, 32'hF);
        check_val("f1_mem_addr", mem_addr_o, 32'h80);
        check_val("f1_data_gnt", {31'h0, data_gnt_o}, 32'h0);
        next_cycle();
        drive_idle();
        @(negedge clk_sys);
        check_val("f1_rvalid", {31'h0, instr_rvalid_o}, 32'h1);
        check_val("f1_rdata", instr_rdata_o, 32'h0000_0013);
        check_val("f1_data_rvalid", {31'h0, data_rvalid_o}, 32'h0);

        // Partial data write, then read back.
        next_cycle();
        drive_data(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk_sys);
        check_val("w_gnt", {31'h0, data_gnt_o}, 32'h1);
        check_val("w_mem_we", {31'h0, mem_we_o}, 32'h1);
        check_val("w_mem_be", {28'h0, mem_be_o}, 32'h3);
        check_val("w_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        next_cycle();
        drive_idle();
        @(negedge clk_sys);
        check_val("w_rvalid", {31'h0, data_rvalid_o}, 32'h1);
        check_val("w_rdata", data_rdata_o, 32'h0);
        next_cycle();
        drive_data(1'b0, 4'hF, 32'h100, 32'h0);
        @(negedge clk_sys);
        check_val("rb_gnt", {31'h0, data_gnt_o}, 32'h1);
        next_cycle();
        drive_idle();
        @(negedge clk_sys);
        check_val("rb_rdata", data_rdata_o, 32'h0000_BEEF);
        check_val("rb_instr_rvalid", {31'h0, instr_rvalid_o}, 32'h0);

        // Starvation: fetch wins cycles 0-3, data forced in cycle 4.
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h80;
            drive_data(1'b0, 4'hF, 32'h100, 32'h0);
            @(negedge clk_sys);
            check_val($sformatf("st%0d_gnts", c), {30'h0, instr_gnt_o, data_gnt_o},
                      (c < 4) ? 32'h2 : 32'h1);
        end
        check_val("st4_instr_rdata", instr_rdata_o, 32'h0000_0013);
        next_cycle();
        drive_idle();
        @(negedge clk_sys);
        check_val("st5_data_rvalid", {31'h0, data_rvalid_o}, 32'h1);
        check_val("st5_data_rdata", data_rdata_o, 32'h0000_BEEF);
        check_val("st5_instr_rvalid", {31'h0, instr_rvalid_o}, 32'h0);

        // Out-of-range fetch just past the window.
        next_cycle();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_2000;
        @(negedge clk_sys);
        check_val("oor_gnt", {31'h0, instr_gnt_o}, 32'h1);
        check_val("oor_mem_req", {31'h0, mem_req_o}, 32'h0);
        check_val("oor_mem_addr", mem_addr_o, 32'h0);
        next_cycle();
        drive_idle();
        @(negedge clk_sys);
        check_val("oor_rvalid_err", {30'h0, instr_rvalid_o, instr_err_o}, 32'h3);
        check_val("oor_rdata", instr_rdata_o, 32'h0);
        check_val("oor_data_err", {31'h0, data_err_o}, 32'h0);

        // Reset pulsed between grant and response drops the response.
        next_cycle();
        drive_data(1'b0, 4'hF, 32'h100, 32'h0);
        @(negedge clk_sys);
        check_val("rr_gnt", {31'h0, data_gnt_o}, 32'h1);
        rst_sys_n = 1'b0;
        #1;
        check_val("rr_in_rst_gnt", {31'h0, data_gnt_o}, 32'h0);
        check_val("rr_in_rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        @(posedge clk_sys);
        #1;
        check_val("rr_in_rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        check_val("rr_in_rst_rdata", data_rdata_o, 32'h0);
        @(negedge clk_sys);
        drive_idle();
        rst_sys_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk_sys);
            check_val($sformatf("rr_post%0d_rvalid", c), {31'h0, data_rvalid_o}, 32'h0);
        end

        // Ten cycles of both requesting; exactly one side loses each cycle.
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h80;
            drive_data(1'b0, 4'hF, 32'h100, 32'h0);
        end
        next_cycle();
        drive_idle();
`ifdef MEM_ARB_STATS_EN
        exp_stall = 32'd10;
`else
        exp_stall = 32'd0;
`endif
        @(negedge clk_sys);
        check_val("stall_cnt", stall_cnt_o, exp_stall);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_mem_arbiter.md
Name: ibex_mem_arbiter

Overview:
- Shares one single-port SRAM (1-cycle read latency) between the Ibex instruction-fetch and data LSU ports.
- Sits between the core and the RAM in the unified-memory build.
- Grants at most one requester per cycle and routes each response back to its owner one cycle after grant.
- Flags out-of-range addresses with a bus error instead of aliasing into the RAM.
- Guarantees the data port forward progress with a bounded-wait starvation counter.

Parameters:
- MEM_START, 32'h00000000, base byte address of the SRAM window.
- MEM_SIZE, 8192, window size in bytes; power of two, >= 4.
- MAX_WAIT, 4, maximum consecutive cycles a pending data request may lose to fetch before it is forced first; range 1..255.

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  async active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error, qualified by instr_rvalid_o
- data_req_i  in  1  LSU request
- data_we_i  in  1  LSU write enable
- data_be_i  in  4  LSU byte enables
- data_addr_i  in  32  LSU byte address
- data_wdata_i  in  32  LSU write data
- data_gnt_o  out  1  LSU accepted this cycle
- data_rvalid_o  out  1  LSU response valid, for reads and writes
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error, qualified by data_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write enable
- mem_be_o  out  4  SRAM byte enables
- mem_addr_o  out  32  SRAM byte address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_req_o
- stall_cnt_o  out  32  contention counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0. Response registers (resp_valid, resp_owner, resp_err) cleared. Starvation counter cleared. Reset mid-transaction discards the outstanding response; no rvalid appears after reset release.
- Reset is clk_sys domain, asynchronous assert, active-low (rst_sys_n).
- Arbitration is combinational within the cycle:
  - Only instr_req_i: grant fetch.
  - Only data_req_i: grant data.
  - Both requesting: grant fetch, unless the starvation counter == MAX_WAIT, in which case grant data.
- Starvation counter:
  - Increments when data_req_i is high and fetch is granted.
  - Clears when data is granted or data_req_i is low.
  - Saturates at MAX_WAIT.
- Grant is same-cycle: x_gnt_o = x_req_i & selected. Every request is granted eventually; there is no back-pressure beyond arbitration loss.
- Range check: in_range = ((addr & ~(MEM_SIZE-1)) == MEM_START).
  - Granted in range: mem_req_o=1, mem_* driven from the winner. Fetch drives we=0, be=4'hF, wdata=0.
  - Granted out of range: gnt still asserted, mem_req_o=0, err response next cycle.
  - When mem_req_o=0, all mem_* outputs are 0.
- Response timing:
  - Exactly one cycle after grant, the owner's rvalid_o=1.
  - rdata_o = mem_rdata_i on an in-range read, 0 on a write or error.
  - err_o = 1 only on an out-of-range access.
  - The non-owner's rvalid, rdata and err are all 0.
- Throughput: one grant per cycle. A new grant may issue in the same cycle the previous response is returned (back-to-back).
- Data in must stay stable only during the grant cycle (OBI semantics). The arbiter holds no request state.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: stall_cnt_o is a 32-bit counter.
  - Increments each cycle either requester is pending but not granted.
  - Wraps at 2^32-1 to 0.
  - Reset to 0.
- Undefined: counter logic is absent and stall_cnt_o is tied to 0.

Decomposition:
- Shared package mem_arb_pkg:
  - owner_e enum (OWNER_INSTR, OWNER_DATA).
  - Localparams: MEM_ADDR_W=32, MEM_BE_W=4.
  - Function in_window(addr, start, size).
- One natural sub-module: mem_arb_resp_reg. It holds the 1-cycle response pipeline stage (valid, owner, err) and demuxes mem_rdata_i to the owners.

Test Plan:
- Single fetch to 0x80 with SRAM word 0x00000013:
  - Expect instr_gnt_o=1 in cycle 0.
  - Expect instr_rvalid_o=1 with rdata 0x00000013 in cycle 1.
  - Expect data outputs 0 throughout.
- Data write to 0x100, wdata 0xDEADBEEF, be 4'b0011:
  - Expect mem_we_o=1 and mem_be_o=4'b0011 in cycle 0.
  - Expect data_rvalid_o=1 with rdata 0 in cycle 1.
  - Read-back of 0x100 returns 0x0000BEEF.
- Continuous fetch requests plus a data read held from cycle 0, MAX_WAIT=4:
  - Fetch is granted in cycles 0-3.
  - Data is granted in cycle 4.
  - Data rvalid arrives in cycle 5.
- Fetch to 0x00002000 with MEM_SIZE=8192:
  - Expect gnt=1 and mem_req_o=0.
  - Next cycle: instr_rvalid_o=1, instr_err_o=1, rdata 0.
- Data read granted, then rst_sys_n pulsed low for 1 cycle before the response:
  - No data_rvalid_o after reset release.
  - All outputs 0 during reset.
- With MEM_ARB_STATS_EN: 10 cycles of both requests held (MAX_WAIT=4) -> stall_cnt_o = 10.
